reaction_stimulus_gen: RTL and testbench
========================================

Name: reaction_stimulus_gen

Overview:
Front-end timebase and stimulus source for the human reaction tester. It produces the signals the reaction FSM consumes:
- debounced start and response levels from raw push-buttons;
- a 13-bit millisecond timer gated by the FSM's timer-enable;
- a pseudo-random wait delay latched when each test starts.

It sits between the board pins and the FSM, and closes the loop on the FSM's timer-enable output.

Parameters:
TICK_DIV, 50000, clk cycles per 1 ms tick (min 2)
DEBOUNCE_MS, 10, ms a raw button must hold a new level before it is accepted (min 1)
RAND_MIN, 1000, minimum random delay in ms; RAND_MIN+2047 must be <= 8191
LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_start  in  1  raw asynchronous start button, active-high
btn_response  in  1  raw asynchronous response button, active-high
timer_en  in  1  timer enable from the reaction FSM
o_start  out  1  debounced start level
o_start_rise  out  1  one-clk pulse, high in the first cycle o_start reads 1
o_response  out  1  debounced response level
o_random_num  out  13  latched random delay in ms
o_timer  out  13  elapsed ms counter
o_ms_tick  out  1  one-clk pulse every TICK_DIV cycles

Behaviour:
- Reset values: o_start=0, o_start_rise=0, o_response=0, o_timer=0, o_ms_tick=0, o_random_num=RAND_MIN, LFSR=LFSR_SEED, prescaler=0, debounce counters=0, synchronizers=0. Reset is honoured mid-operation from any state.
- Prescaler:
  - free-running 0..TICK_DIV-1, wraps to 0;
  - o_ms_tick registered, high for exactly the one cycle the count equals TICK_DIV-1;
  - independent of timer_en.
- Synchronizer: each raw button passes through a 2-flop synchronizer; the second flop is the "synced" value.
- Debounce (per button, identical):
  - stable register plus a ms counter;
  - when synced == stable, the counter clears to 0 every cycle;
  - when synced != stable, the counter increments on each o_ms_tick;
  - when the counter reaches DEBOUNCE_MS while still mismatched, stable <= synced and the counter clears;
  - a glitch shorter than DEBOUNCE_MS ticks never changes stable;
  - o_start / o_response are the stable registers.
- o_start_rise: registered, high in the same cycle o_start first becomes 1, low otherwise. Falling edges produce no pulse.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1;
  - shifts every clk regardless of other inputs;
  - if the state is ever all-zero, the next state is LFSR_SEED (lock-up guard).
- Random latch:
  - on a cycle with o_start_rise=1, o_random_num <= RAND_MIN + LFSR[10:0], using the pre-shift LFSR value, in 13-bit unsigned arithmetic;
  - range RAND_MIN..RAND_MIN+2047;
  - otherwise o_random_num holds.
- Timer, priority highest first:
  1. o_start_rise=1 -> o_timer <= 0.
  2. Else timer_en=1 and o_ms_tick=1 and o_timer != 8191 -> o_timer <= o_timer+1.
  3. Else hold. Saturates at 8191, no wrap. With timer_en=0 it freezes, so the FSM can still compute the response time in its done state.
- Latency: the clear and random latch triggered by o_start_rise are visible on outputs one clk later. A timer increment is visible the clk after the tick cycle.
- Simultaneous o_start_rise and o_ms_tick with timer_en=1: clear wins, timer=0.
- Both buttons may change together; the two debouncers are fully independent.

Test Plan:
(TICK_DIV=4, DEBOUNCE_MS=2, RAND_MIN=1000, LFSR_SEED=16'hACE1 unless noted.)
1. Reset/tick: release rst, idle 20 clks -> all outputs at reset values except o_ms_tick. o_ms_tick pulses on cycles 4, 8, 12… after reset release (1 clk wide), every 4 clks.
2. Debounce accept/reject:
   - btn_start high for 5 clks then low -> o_start never rises;
   - btn_start held high 16 clks -> o_start rises after the 2 sync flops plus 2 ms ticks, with o_start_rise high exactly 1 clk.
3. Random latch:
   - check o_random_num == 1000 + LFSR[10:0] at the rise cycle;
   - value lies in 1000..3047;
   - a second press later yields a value recomputed from the then-current LFSR state.
4. Timer gating: after start, timer_en=1 for 40 clks -> o_timer=10. Drop timer_en -> o_timer holds 10 for 100 clks.
5. Saturation/clear:
   - force TICK_DIV=2, timer_en=1 for 20000 clks -> o_timer stops at 8191;
   - new start press -> o_timer=0 one clk after o_start_rise, including the case where o_start_rise coincides with o_ms_tick.
6. Async reset mid-count: assert rst between clock edges while o_timer=37 and o_start=1 -> outputs return to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/reaction_stimulus_gen.sv
// reaction_stimulus_gen
//   Timebase and stimulus front end for the reaction tester. Produces the
//   debounced button levels, a gated millisecond timer and a random wait
//   delay that the reaction FSM consumes.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   btn_start     raw start push-button (asynchronous)
//   btn_response  raw response push-button (asynchronous)
//   timer_en      timer enable from the reaction FSM
//   o_start       debounced start level
//   o_start_rise  one-clk pulse in the first cycle o_start reads 1
//   o_response    debounced response level
//   o_random_num  random delay in ms, latched on each o_start_rise
//   o_timer       elapsed ms, saturating at 8191
//   o_ms_tick     one-clk pulse every TICK_DIV clocks
module reaction_stimulus_gen #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned RAND_MIN    = 1000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_response,
    input  logic        timer_en,
    output logic        o_start,
    output logic        o_start_rise,
    output logic        o_response,
    output logic [12:0] o_random_num,
    output logic [12:0] o_timer,
    output logic        o_ms_tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_MS + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LIMIT  = DW'(DEBOUNCE_MS);
    localparam logic [12:0]   RAND_BASE = 13'(RAND_MIN);
    localparam logic [12:0]   TIMER_MAX = '1;

    // ------------------------------------------------------------------
    // Millisecond prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_cnt;
    logic [PW-1:0] pre_next;

    always_comb begin
        pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
    end

    // The tick is registered from the next count so it is high exactly
    // while the count sits at TICK_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt   <= '0;
            o_ms_tick <= 1'b0;
        end else begin
            pre_cnt   <= pre_next;
            o_ms_tick <= (pre_next == PRE_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Synchronizers and debouncers; bit 0 = start, bit 1 = response
    // ------------------------------------------------------------------
    logic [1:0]         meta;
    logic [1:0]         synced;
    logic [1:0]         stable;
    logic [1:0][DW-1:0] db_cnt;
    logic [1:0]         mismatch;
    logic [1:0]         accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= {btn_response, btn_start};
            synced <= meta;
        end
    end

    always_comb begin
        mismatch = '0;
        accept   = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            mismatch[i] = synced[i] ^ stable[i];
            accept[i]   = mismatch[i] && (db_cnt[i] == DB_LIMIT);
        end
    end

    // A new level is accepted one cycle after the counter reaches the
    // limit, and only if the mismatch is still present in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            db_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (!mismatch[i]) begin
                    db_cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= synced[i];
                    db_cnt[i] <= '0;
                end else if (o_ms_tick) begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign o_start    = stable[0];
    assign o_response = stable[1];

    // Rise pulse is registered alongside stable, so both change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_start_rise <= 1'b0;
        end else begin
            o_start_rise <= accept[0] & synced[0];
        end
    end

    // ------------------------------------------------------------------
    // LFSR x^16+x^14+x^13+x^11+1, free running
    // ------------------------------------------------------------------
    logic [15:0] lfsr;
    logic        lfsr_fb;

    always_comb begin
        lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr == '0) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    // ------------------------------------------------------------------
    // Random delay latch and ms timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_random_num <= RAND_BASE;
        end else if (o_start_rise) begin
            o_random_num <= RAND_BASE + {2'b00, lfsr[10:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_timer <= '0;
        end else if (o_start_rise) begin
            o_timer <= '0;
        end else if (timer_en && o_ms_tick && (o_timer != TIMER_MAX)) begin
            o_timer <= o_timer + 13'd1;
        end
    end

endmodule

// File: tb/tb_reaction_stimulus_gen.sv
// tb_reaction_stimulus_gen
//   Scoreboard bench for reaction_stimulus_gen. Two instances share the
//   inputs: a slow one (TICK_DIV=4) and a fast one (TICK_DIV=2, where a
//   start rise lands on a tick). A reference model produces the expected
//   outputs each clock and queues them; a monitor pops and compares.
module tb_reaction_stimulus_gen;

    localparam int DEB   = 2;
    localparam int RMIN  = 1000;
    localparam bit [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_start = 1'b0;
    logic btn_response = 1'b0;
    logic timer_en = 1'b0;

    logic        s_start, s_rise, s_resp, s_tick;
    logic [12:0] s_rnd, s_timer;
    logic        f_start, f_rise, f_resp, f_tick;
    logic [12:0] f_rnd, f_timer;

    always #5 clk = ~clk;

    reaction_stimulus_gen #(
        .TICK_DIV(4), .DEBOUNCE_MS(DEB), .RAND_MIN(RMIN), .LFSR_SEED(SEED)
    ) dut_s (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_response(btn_response),
        .timer_en(timer_en), .o_start(s_start), .o_start_rise(s_rise),
        .o_response(s_resp), .o_random_num(s_rnd), .o_timer(s_timer),
        .o_ms_tick(s_tick)
    );

    reaction_stimulus_gen #(
        .TICK_DIV(2), .DEBOUNCE_MS(DEB), .RAND_MIN(RMIN), .LFSR_SEED(SEED)
    ) dut_f (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_response(btn_response),
        .timer_en(timer_en), .o_start(f_start), .o_start_rise(f_rise),
        .o_response(f_resp), .o_random_num(f_rnd), .o_timer(f_timer),
        .o_ms_tick(f_tick)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int        phase;      // clocks into the current ms
        bit        tick;
        bit [1:0]  raw_d1;     // button samples delayed one clock
        bit [1:0]  raw_d2;     // button samples delayed two clocks
        bit [1:0]  level;      // accepted debounced levels
        int        ticks_s;    // ms ticks seen while start level disagrees
        int        ticks_r;
        bit        rise;
        int        rnd;
        int        timer;
        bit [15:0] lfsr;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.phase = 0; m.tick = 0; m.raw_d1 = 0; m.raw_d2 = 0; m.level = 0;
        m.ticks_s = 0; m.ticks_r = 0; m.rise = 0; m.rnd = RMIN; m.timer = 0;
        m.lfsr = SEED;
        return m;
    endfunction

    function automatic bit [15:0] lfsr_next(input bit [15:0] l);
        int exps[4] = '{16, 14, 13, 11};
        bit fb = 1'b0;
        if (l == 16'h0) return SEED;
        foreach (exps[k]) fb ^= l[exps[k]-1];
        return {l[14:0], fb};
    endfunction

    // A disagreeing level must survive DEB ticks and still disagree
    // afterwards before it is accepted; agreement forgets the history.
    function automatic void debounce(input bit seen, input bit tick,
                                     inout bit lvl, inout int ticks);
        if (seen == lvl) ticks = 0;
        else if (ticks >= DEB) begin lvl = seen; ticks = 0; end
        else if (tick) ticks = ticks + 1;
    endfunction

    function automatic model_t model_step(input model_t m, input bit bs,
                                          input bit br, input bit en, input int div);
        model_t n = m;
        bit l0 = m.level[0];
        bit l1 = m.level[1];
        int t0 = m.ticks_s;
        int t1 = m.ticks_r;
        n.phase = (m.phase + 1) % div;
        n.tick  = (n.phase == div - 1);
        debounce(m.raw_d2[0], m.tick, l0, t0);
        debounce(m.raw_d2[1], m.tick, l1, t1);
        n.level   = {l1, l0};
        n.ticks_s = t0;
        n.ticks_r = t1;
        n.raw_d2  = m.raw_d1;
        n.raw_d1  = {br, bs};
        n.rise    = l0 && !m.level[0];
        if (m.rise) n.rnd = RMIN + int'(m.lfsr % 2048);
        if (m.rise) n.timer = 0;
        else if (en && m.tick && m.timer < 8191) n.timer = m.timer + 1;
        n.lfsr = lfsr_next(m.lfsr);
        return n;
    endfunction

    model_t ms, mf, es, ef;
    model_t q_s[$];
    model_t q_f[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_cnt_s = 0;
    int rise_cnt_s = 0;
    int coinc_f = 0;
    bit prev_rise_s = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string name, input model_t e, input bit st,
                             input bit rs, input bit rp, input logic [12:0] rn,
                             input logic [12:0] tm, input bit tk);
        checks++;
        if (st != e.level[0] || rs != e.rise || rp != e.level[1] ||
            int'(rn) != e.rnd || int'(tm) != e.timer || tk != e.tick) begin
            errors++;
            $display("FAIL %s cycle %0d: got start=%0b rise=%0b resp=%0b rnd=%0d timer=%0d tick=%0b expected start=%0b rise=%0b resp=%0b rnd=%0d timer=%0d tick=%0b",
                     name, cyc, st, rs, rp, rn, tm, tk,
                     e.level[0], e.rise, e.level[1], e.rnd, e.timer, e.tick);
        end
    endtask

    // Model: advances on every clock edge and queues the expected outputs.
    initial begin
        ms = model_reset();
        mf = model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                ms = model_reset();
                mf = model_reset();
            end else begin
                ms = model_step(ms, btn_start, btn_response, timer_en, 4);
                mf = model_step(mf, btn_start, btn_response, timer_en, 2);
            end
            q_s.push_back(ms);
            q_f.push_back(mf);
        end
    end

    // Monitor: samples 1 time unit after the edge and compares.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q_s.size() > 0) begin
                es = q_s.pop_front();
                cmp_model("scoreboard_slow", es, s_start, s_rise, s_resp, s_rnd, s_timer, s_tick);
            end
            if (q_f.size() > 0) begin
                ef = q_f.pop_front();
                cmp_model("scoreboard_fast", ef, f_start, f_rise, f_resp, f_rnd, f_timer, f_tick);
            end
            if (s_tick) tick_cnt_s++;
            if (s_rise) rise_cnt_s++;
            if (prev_rise_s)
                check("rand_range", int'(s_rnd >= 13'd1000 && s_rnd <= 13'd3047), 1);
            prev_rise_s = s_rise;
            if (f_rise && f_tick) coinc_f++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_slow(input string tag);
        check({tag, "_start"}, s_start, 0);
        check({tag, "_rise"}, s_rise, 0);
        check({tag, "_resp"}, s_resp, 0);
        check({tag, "_rnd"}, s_rnd, RMIN);
        check({tag, "_timer"}, s_timer, 0);
    endtask

    int snap;

    initial begin
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;

        // Reset state and tick cadence
        snap = tick_cnt_s;
        cycles(20);
        check("tick_count_20clk", tick_cnt_s - snap, 5);
        check_reset_slow("idle");

        // Short glitch is rejected
        snap = rise_cnt_s;
        btn_start = 1'b1;
        cycles(5);
        btn_start = 1'b0;
        cycles(20);
        check("glitch_no_rise", rise_cnt_s - snap, 0);
        check("glitch_start_low", s_start, 0);

        // Held press is accepted with a single-cycle rise
        snap = rise_cnt_s;
        btn_start = 1'b1;
        cycles(16);
        check("press1_rise_once", rise_cnt_s - snap, 1);
        check("press1_start_high", s_start, 1);

        // Second press at a random offset
        btn_start = 1'b0;
        cycles(20);
        check("release_start_low", s_start, 0);
        cycles($urandom_range(0, 7));
        snap = rise_cnt_s;
        btn_start = 1'b1;
        cycles(16);
        check("press2_rise_once", rise_cnt_s - snap, 1);

        // Timer gating
        timer_en = 1'b1;
        cycles(40);
        timer_en = 1'b0;
        cycles(1);
        check("timer_gated_10", s_timer, 10);
        cycles(100);
        check("timer_hold_10", s_timer, 10);

        // Saturation
        timer_en = 1'b1;
        cycles(33000);
        check("timer_sat_slow", s_timer, 8191);
        check("timer_sat_fast", f_timer, 8191);

        // Press with timer running: fast instance rise coincides with tick
        btn_start = 1'b0;
        cycles(20);
        snap = coinc_f;
        btn_start = 1'b1;
        cycles(16);
        check("fast_rise_on_tick", int'(coinc_f > snap), 1);

        // Clear on press with timer frozen
        timer_en = 1'b0;
        btn_start = 1'b0;
        cycles(20);
        btn_start = 1'b1;
        cycles(16);
        check("timer_cleared_on_press", s_timer, 0);
        timer_en = 1'b1;
        cycles(148);
        timer_en = 1'b0;
        check("timer_37", s_timer, 37);
        check("start_held", s_start, 1);

        // Asynchronous reset between edges
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_slow("async_rst");
        check("async_rst_tick", s_tick, 0);
        check("async_rst_fast_timer", f_timer, 0);
        cycles(2);
        rst = 1'b0;

        // Response button
        btn_start = 1'b0;
        btn_response = 1'b1;
        cycles(20);
        check("response_high", s_resp, 1);
        btn_response = 1'b0;
        cycles(20);
        check("response_low", s_resp, 0);

        // Random traffic on both buttons and the enable
        for (int i = 0; i < 80; i++) begin
            btn_start    = 1'($urandom_range(0, 1));
            btn_response = 1'($urandom_range(0, 1));
            timer_en     = 1'($urandom_range(0, 1));
            cycles($urandom_range(1, 14));
        end
        cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
